// File: rtl/ssd_bcd_driver_if.sv
// Interface bundling the conversion handshake and display pins of
// ssd_bcd_driver. The driving side (CPU/bench) uses the master modport,
// the driver block uses the slave modport.
interface ssd_bcd_driver_if #(
  parameter int IN_W = 13
);
  logic [IN_W-1:0] value;
  logic            load;
  logic            busy;
  logic            done;
  logic [15:0]     bcd_out;
  logic [3:0]      anode;
  logic [6:0]      seg;

  modport master (
    output value, load,
    input  busy, done, bcd_out, anode, seg
  );

  modport slave (
    input  value, load,
    output busy, done, bcd_out, anode, seg
  );
endinterface

// File: rtl/ssd_bcd_driver.sv
// ssd_bcd_driver: binary to 4-digit BCD (sequential double-dabble, one input
// bit per cycle) plus a continuously scanning common-anode 7-segment driver.
// Optional macro SSD_BLANK_EN enables leading-zero blanking; when undefined
// all four digits are always shown.
module ssd_bcd_driver #(
  parameter int IN_W        = 13,
  parameter int REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  ssd_bcd_driver_if.slave  bus
);

  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int REF_W = $clog2(REFRESH_DIV);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state;
  logic [IN_W-1:0]   bin_sr;
  logic [15:0]       scratch;
  logic [CNT_W-1:0]  bit_cnt;
  logic              busy_r;
  logic              done_r;
  logic [15:0]       bcd_r;

  logic [15:0]       corrected;
  logic [15:0]       scratch_next;
  logic [IN_W-1:0]   bin_next;

  logic [REF_W-1:0]  ref_cnt;
  logic              ref_wrap;
  logic [1:0]        digit_idx;
  logic [1:0]        idx_next;
  logic [3:0]        nibble;
  logic              blank;
  logic [3:0]        anode_next;
  logic [6:0]        seg_next;
  logic [3:0]        anode_r;
  logic [6:0]        seg_r;

  // Active-low gfedcba pattern for one BCD digit; non-BCD codes go dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // One double-dabble step: add-3 correction on each nibble, then shift left.
  always_comb begin
    corrected = scratch;
    for (int unsigned i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        corrected[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    {scratch_next, bin_next} = {corrected, bin_sr} << 1;
  end

  // Conversion FSM: capture on load in IDLE, IN_W shift steps, then publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bin_sr  <= '0;
      scratch <= '0;
      bit_cnt <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      bcd_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            bin_sr  <= bus.value;
            scratch <= '0;
            bit_cnt <= '0;
            busy_r  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_next;
          bin_sr  <= bin_next;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(IN_W - 1)) begin
            bcd_r  <= scratch_next;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Next scan slot and the digit pattern it should show.
  always_comb begin
    ref_wrap = (ref_cnt == REF_W'(REFRESH_DIV - 1));
    idx_next = ref_wrap ? digit_idx + 2'd1 : digit_idx;
    nibble   = bcd_r[{idx_next, 2'b00} +: 4];
`ifdef SSD_BLANK_EN
    case (idx_next)
      2'd1:    blank = (bcd_r[15:4]  == 12'd0);
      2'd2:    blank = (bcd_r[15:8]  == 8'd0);
      2'd3:    blank = (bcd_r[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    anode_next = blank ? 4'b1111 : ~(4'b0001 << idx_next);
    seg_next   = blank ? 7'b1111111 : seg_decode(nibble);
  end

  // Refresh divider and registered display outputs. Segments are re-evaluated
  // every cycle so a new bcd_out appears immediately without disturbing the scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt   <= '0;
      digit_idx <= '0;
      anode_r   <= 4'b1110;
      seg_r     <= 7'b1000000;
    end else begin
      ref_cnt   <= ref_wrap ? '0 : ref_cnt + 1'b1;
      digit_idx <= idx_next;
      anode_r   <= anode_next;
      seg_r     <= seg_next;
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.bcd_out = bcd_r;
  assign bus.anode   = anode_r;
  assign bus.seg     = seg_r;

endmodule

// File: tb/tb_ssd_bcd_driver.sv
// Self-checking bench for ssd_bcd_driver: scoreboard of expected BCD results
// popped on each done pulse, plus direct checks of reset, handshake and scan.
module tb_ssd_bcd_driver;

  localparam int IN_W        = 13;
  localparam int REFRESH_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ssd_bcd_driver_if #(.IN_W(IN_W)) bus ();

  ssd_bcd_driver #(.IN_W(IN_W), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_cmp      = 0;
  int unsigned n_err      = 0;
  int unsigned done_count = 0;
  logic [15:0] exp_q[$];
  logic        prev_done  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int unsigned v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'b1000000;  4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;  4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;  4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;  4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;  4'd9: s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (bus.done) begin
        done_count++;
        if (prev_done)
          check_eq("done_width", 32'(bus.done), 32'd0);
        if (exp_q.size() == 0)
          check_eq("spurious_done", 32'(bus.done), 32'd0);
        else
          check_eq("bcd_out", 32'(bus.bcd_out), 32'(exp_q.pop_front()));
      end
      prev_done = bus.done;
    end
  end

  // All tasks below start and end just after a rising edge.
  task automatic wait_idle();
    logic ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!bus.busy) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) check_eq("wait_idle", 32'(bus.busy), 32'd0);
  endtask

  task automatic start_load(input int unsigned v);
    bus.value = IN_W'(v);
    bus.load  = 1'b1;
    exp_q.push_back(to_bcd(v));
    @(posedge clk); #1;
    bus.load  = 1'b0;
  endtask

  task automatic convert(input int unsigned v);
    int unsigned busy_n = 0;
    logic got = 1'b0;
    wait_idle();
    start_load(v);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin got = 1'b1; break; end
      if (bus.busy) busy_n++;
    end
    check_eq("done_seen", 32'(got), 32'd1);
    check_eq("busy_cycles", busy_n, IN_W);
    @(posedge clk); #1;
  endtask

  // Observe five scan slots starting at digit 0 and compare to the model.
  task automatic check_scan(input logic [15:0] bcd);
    logic [3:0] prev = bus.anode;
    logic found = 1'b0;
    logic [3:0] exp_an;
    logic [6:0] exp_sg;
    int unsigned d;
    logic blank;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.anode == 4'b1110 && prev != 4'b1110) begin found = 1'b1; break; end
      prev = bus.anode;
    end
    check_eq("scan_sync", 32'(found), 32'd1);
    for (int i = 0; i < 20; i++) begin
      d = (i / 4) % 4;
      blank = 1'b0;
`ifdef SSD_BLANK_EN
      blank = (d != 0) && ((bcd >> (4 * d)) == 16'd0);
`endif
      exp_an = blank ? 4'b1111 : ~(4'b0001 << d);
      exp_sg = blank ? 7'b1111111 : seg_of(bcd[4*d +: 4]);
      check_eq("scan_anode", 32'(bus.anode), 32'(exp_an));
      check_eq("scan_seg", 32'(bus.seg), 32'(exp_sg));
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned dc0;
    bus.value = '0;
    bus.load  = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rst_busy",  32'(bus.busy),    32'd0);
    check_eq("rst_done",  32'(bus.done),    32'd0);
    check_eq("rst_bcd",   32'(bus.bcd_out), 32'h0000);
    check_eq("rst_anode", 32'(bus.anode),   32'b1110);
    check_eq("rst_seg",   32'(bus.seg),     32'b1000000);

    convert(1234);
    check_scan(16'h1234);
    convert(8191);
    check_eq("bcd_8191", 32'(bus.bcd_out), 32'h8191);
    convert(0);
    check_scan(16'h0000);

    // Loads at cycles 3 and 13 of a running conversion must be ignored.
    wait_idle();
    dc0 = done_count;
    start_load(500);
    repeat (2) @(posedge clk);
    #1; bus.value = IN_W'(9); bus.load = 1'b1;
    @(posedge clk); #1; bus.load = 1'b0;
    repeat (9) @(posedge clk);
    #1; bus.load = 1'b1;
    @(posedge clk); #1; bus.load = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("collision_dones", done_count - dc0, 32'd1);
    check_eq("collision_bcd", 32'(bus.bcd_out), 32'h0500);
    check_eq("collision_busy", 32'(bus.busy), 32'd0);
    check_scan(16'h0500);

    // Reset at cycle 6 of a conversion aborts it without a done pulse.
    wait_idle();
    dc0 = done_count;
    start_load(4321);
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    exp_q.delete();
    check_eq("midrst_busy", 32'(bus.busy), 32'd0);
    check_eq("midrst_bcd", 32'(bus.bcd_out), 32'h0000);
    repeat (20) @(posedge clk);
    #1;
    check_eq("midrst_dones", done_count - dc0, 32'd0);
    convert(77);
    check_eq("bcd_77", 32'(bus.bcd_out), 32'h0077);

    convert(7);
    check_scan(16'h0007);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ssd_bcd_driver.md
Name: ssd_bcd_driver

Overview:
- Downstream consumer of the CPU's seven-segment output path: takes a binary value from the core, converts it to 4-digit BCD with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto a common 4-anode seven-segment display.
- Sits between the processor top level and the board display pins.
- Conversion runs once per load request, one bit per cycle; the display scan runs continuously from its own refresh divider.

Parameters:
- IN_W, 13, width of the binary input; legal range 1..13, so the maximum value is 8191 and always fits 4 decimal digits.
- REFRESH_DIV, 100000, clk cycles each digit stays lit; legal minimum 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- value  in  IN_W  binary number to display.
- load  in  1  request a conversion of value; sampled only in IDLE.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when bcd_out updates.
- bcd_out  out  16  latched BCD result, digit3..digit0 in [15:12]..[3:0].
- anode  out  4  active-low digit enables; exactly one bit low, or none low when blanked.
- seg  out  7  active-low segments, order {g,f,e,d,c,b,a}.

Behaviour:
- Reset values (rst sampled high at an edge):
  - busy=0, done=0, bcd_out=16'h0000.
  - FSM=IDLE, refresh counter=0, digit index=0.
  - anode=4'b1110, seg=7'b1000000 (shows "0").
- Reset mid-conversion aborts the conversion; bcd_out returns to 0 and no done pulse is issued.
- Conversion FSM states: IDLE, SHIFT.
  - IDLE, load=1 at edge N:
    - Capture value into the binary shift register and clear the BCD scratch register.
    - Set bit counter=0, busy=1, go to SHIFT.
  - SHIFT, one edge per input bit:
    - Each nibble of the scratch register that is >=5 gets +3.
    - Then {scratch, binary} shifts left by 1 and the counter increments.
  - The IN_W-th shift occurs at edge N+IN_W. On that same edge:
    - The corrected, shifted result is written to bcd_out.
    - done=1, busy=0, FSM returns to IDLE.
  - Latency: bcd_out valid and done high in the cycle after edge N+IN_W. done is high for exactly one cycle.
- load while busy=1 is ignored: it is not queued and it does not restart the conversion.
- load asserted at the same edge the FSM returns to IDLE is ignored. A new load is accepted at the first edge where the FSM is already in IDLE.
- bcd_out holds its value between conversions; the display always shows bcd_out, never the scratch register.
- Refresh:
  - The counter counts 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, the digit index increments modulo 4 (3 wraps to 0).
  - anode = ~(4'b0001 << index).
- Segment decode of the nibble selected by the digit index (active low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibbles 10..15 cannot occur; decode them to 1111111.
- anode and seg are registered. They change on the same edge the digit index changes, so they are always mutually consistent.
- Refresh is independent of conversion. A done pulse updates the displayed digits on the next cycle without resetting the scan.

Optional Feature:
- Macro: SSD_BLANK_EN.
- Defined: leading-zero blanking.
  - A digit above the most significant nonzero digit of bcd_out has its anode driven high and seg=7'b1111111.
  - Digit 0 is never blanked, so 0 displays as "0".
  - Blanking is evaluated from the current bcd_out each scan slot.
- Not defined: all four digits are always shown, including leading zeros.

Test Plan:
- Reset: rst=1 for 1 edge, then release with REFRESH_DIV=4 -> busy=0, done=0, bcd_out=16'h0000, anode=4'b1110, seg=7'b1000000.
- Basic conversion: value=1234, load=1 for one cycle, IN_W=13 -> busy high for 13 cycles, done single pulse, bcd_out=16'h1234; value=8191 gives 16'h8191; value=0 gives 16'h0000.
- Scan: REFRESH_DIV=4 with bcd_out=16'h1234 -> anode sequence 1110,1101,1011,0111,1110, each held 4 cycles; seg sequence 0011001 ("4"), 0110000 ("3"), 0100100 ("2"), 1111001 ("1").
- Load collision: value=500 loaded, then load=1 with value=9 at cycles 3 and 13 of that conversion -> both ignored, a single done pulse, bcd_out=16'h0500.
- Reset mid-operation: value=4321 loaded, rst=1 at cycle 6 -> busy=0, bcd_out=0, no done pulse; a fresh load of 77 then gives 16'h0077.
- With SSD_BLANK_EN: bcd_out=16'h0007 -> anodes 1..3 never low and seg=1111111 during those slots; digit 0 shows 1111000; bcd_out=0 shows "0" on digit 0 only.
